led_trail_pwm: RTL and testbench



---
 rtl/led_trail_pwm_if.sv | 8 +
 rtl/led_trail_pwm.sv | 41 ++++
 tb/tb_led_trail_pwm.sv | 107 ++++++++++
 3 files changed

// File: rtl/led_trail_pwm_if.sv
// led_trail_pwm_if: LED pattern in, trail enable and PWM LED drive out
interface led_trail_pwm_if;
  logic [3:0] led_in;
  logic       trail_en;
  logic [3:0] led_out;
  modport master (output led_in, trail_en, input led_out);
  modport slave  (input led_in, trail_en, output led_out);
endinterface

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: drives lit LEDs at full brightness and fades newly dark LEDs linearly via PWM
module led_trail_pwm #(
  parameter int          PWM_BITS   = 8,
  parameter logic [24:0] DECAY_DIV  = 25'd781_250,
  parameter int          DECAY_STEP = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  led_trail_pwm_if.slave   bus
);
  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [24:0]         decay_cnt;
  logic [PWM_BITS-1:0] level [4];
  logic                tick;
  logic [3:0]          on;
  assign tick = decay_cnt == DECAY_DIV - 25'd1;
  always_comb begin
    on = '0;
    for (int i = 0; i < 4; i++) on[i] = (level[i] == MAX) | (pwm_cnt < level[i]);
  end
  // a lit input wins over both the enable and a coincident tick
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pwm_cnt     <= '0;
      decay_cnt   <= '0;
      bus.led_out <= 4'b1111;
      for (int i = 0; i < 4; i++) level[i] <= '0;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      decay_cnt   <= tick ? 25'd0 : decay_cnt + 25'd1;
      bus.led_out <= ~on;
      for (int i = 0; i < 4; i++)
        level[i] <= !bus.led_in[i] ? MAX :
                    !bus.trail_en  ? '0 :
                    tick           ? (level[i] > STEP ? level[i] - STEP : '0) :
                                     level[i];
    end
  end
endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm: directed and random stimulus checked against a tick-counting fade model
module tb_led_trail_pwm;
  localparam int MAXV = 15, DIV = 4, STEP = 4;
  logic sys_clk = 0, sys_rst = 1;
  int checks = 0, failures = 0;
  int cyc = 0;
  bit active [4];
  int n_ticks [4];
  logic [3:0] exp_out = 4'b1111;
  led_trail_pwm_if bus ();
  led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(25'd4), .DECAY_STEP(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  function automatic int lvl(int i);
    int l;
    l = active[i] ? MAXV - STEP * n_ticks[i] : 0;
    return l < 0 ? 0 : l;
  endfunction
  // brightness = MAX minus one STEP per tick elapsed since going dark
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      cyc = 0;
      exp_out = 4'b1111;
      for (int i = 0; i < 4; i++) begin active[i] = 0; n_ticks[i] = 0; end
    end else begin
      for (int i = 0; i < 4; i++)
        exp_out[i] = !(lvl(i) == MAXV || (cyc % 16) < lvl(i));
      for (int i = 0; i < 4; i++) begin
        if (!bus.led_in[i]) begin active[i] = 1; n_ticks[i] = 0; end
        else if (!bus.trail_en) active[i] = 0;
        else if ((cyc % DIV) == DIV - 1 && n_ticks[i] < 100) n_ticks[i]++;
      end
      cyc++;
    end
  end
  task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask
  task automatic run(int n, string tag);
    repeat (n) begin
      @(negedge sys_clk);
      check(tag, bus.led_out, exp_out);
    end
  endtask
  initial begin
    logic [3:0] flow [4];
    flow[0] = 4'b1110; flow[1] = 4'b1101; flow[2] = 4'b1011; flow[3] = 4'b0111;
    bus.led_in = 4'b0000;
    bus.trail_en = 1;
    repeat (3) begin @(negedge sys_clk); check("reset_hold", bus.led_out, 4'b1111); end
    sys_rst = 0;
    @(negedge sys_clk); check("release_1", bus.led_out, 4'b1111);
    @(negedge sys_clk); check("release_2", bus.led_out, 4'b0000);
    run(4, "all_lit");
    bus.led_in = 4'b1110;
    run(20, "steady");
    bus.led_in = 4'b1111;
    run(24, "fade");
    check("fade_done", bus.led_out, 4'b1111);
    bus.led_in = 4'b1110;
    run(6, "relight_a");
    bus.led_in = 4'b1111;
    run(9, "relight_fade");
    bus.led_in = 4'b1110;
    run(6, "relight_b");
    bus.trail_en = 0;
    for (int k = 0; k < 8; k++) begin
      bus.led_in = flow[k % 4];
      run(3, "pass");
    end
    bus.trail_en = 1;
    bus.led_in = 4'b1101;
    run(4, "pre_rst");
    bus.led_in = 4'b1111;
    run(3, "mid_fade");
    sys_rst = 1;
    run(1, "mid_rst");
    sys_rst = 0;
    run(20, "post_rst");
    check("post_rst_dark", bus.led_out, 4'b1111);
    bus.led_in = 4'b1101;
    run(4, "pre_drop");
    bus.led_in = 4'b1111;
    run(3, "mid_fade2");
    bus.trail_en = 0;
    run(6, "drop_en");
    bus.trail_en = 1;
    run(6, "reen");
    for (int k = 0; k < 300; k++) begin
      sys_rst = ($urandom_range(0, 29) == 0);
      bus.trail_en = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: bus.led_in = 4'b1111;
        1: bus.led_in = flow[$urandom_range(0, 3)];
        default: bus.led_in = 4'($urandom);
      endcase
      if (sys_rst) begin run(1, "rnd_rst"); sys_rst = 0; end
      run($urandom_range(1, 25), "rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
